// File: rtl/ifft_cp_pkg.sv
// Shared constants, state encoding and CP-length helper for the IFFT CP scheduler.
// IFFT_CP_SCHED_EXT_CP_EN enables extended-CP slot support in the users of this package.
package ifft_cp_pkg;

  localparam int unsigned DEF_IFFT_SIZE = 2048;
  localparam int unsigned DEF_ADDR_W    = 11;
  localparam int unsigned DEF_CP_LONG   = 160;
  localparam int unsigned DEF_CP_SHORT  = 144;
  localparam int unsigned DEF_SYMS_SLOT = 14;
  localparam int unsigned CP_EXT        = 512;
  localparam int unsigned SYMS_EXT      = 12;
  localparam int unsigned LONG_SYM_A    = 0;
  localparam int unsigned LONG_SYM_B    = 7;
  localparam int unsigned CP_LEN_W      = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CP,
    ST_BODY,
    ST_DONE
  } state_t;

  function automatic logic [CP_LEN_W-1:0] cp_len_f(input logic [3:0] idx, input logic ext,
                                                   input logic [CP_LEN_W-1:0] cp_long,
                                                   input logic [CP_LEN_W-1:0] cp_short);
    if (ext)
      return CP_LEN_W'(CP_EXT);
    else if (idx == 4'(LONG_SYM_A) || idx == 4'(LONG_SYM_B))
      return cp_long;
    else
      return cp_short;
  endfunction

endpackage

// File: rtl/ifft_cp_sched_cp_sym_counter.sv
// Symbol index within the slot, extended-CP latch and CP length / start-address decode.
// The ext_cp port and latch exist only with IFFT_CP_SCHED_EXT_CP_EN defined.
module cp_sym_counter
  import ifft_cp_pkg::*;
#(
  parameter int unsigned IFFT_SIZE = DEF_IFFT_SIZE,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned CP_LONG   = DEF_CP_LONG,
  parameter int unsigned CP_SHORT  = DEF_CP_SHORT,
  parameter int unsigned SYMS_SLOT = DEF_SYMS_SLOT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                adv_i,
`ifdef IFFT_CP_SCHED_EXT_CP_EN
  input  logic                idle_i,
  input  logic                ext_cp_i,
`endif
  output logic [3:0]          sym_idx_o,
  output logic                last_sym_o,
  output logic [CP_LEN_W-1:0] cp_len_o,
  output logic [ADDR_W-1:0]   start_addr_o
);

  logic [3:0] idx_q, idx_d;
  logic [3:0] last_idx;
  logic       ext_eff;

`ifdef IFFT_CP_SCHED_EXT_CP_EN
  logic ext_q;

  // At slot start the live input decides the first symbol's CP, then it is held.
  always_comb begin
    ext_eff = ext_q;
    if (idle_i && idx_q == '0)
      ext_eff = ext_cp_i;
  end

  always_ff @(posedge clk) begin
    if (rst) ext_q <= 1'b0;
    else     ext_q <= ext_eff;
  end
`else
  assign ext_eff = 1'b0;
`endif

  always_comb begin
    last_idx   = ext_eff ? 4'(SYMS_EXT - 1) : 4'(SYMS_SLOT - 1);
    last_sym_o = (idx_q == last_idx);
    idx_d      = idx_q;
    if (adv_i)
      idx_d = last_sym_o ? '0 : idx_q + 4'd1;
    cp_len_o     = cp_len_f(idx_q, ext_eff, CP_LEN_W'(CP_LONG), CP_LEN_W'(CP_SHORT));
    start_addr_o = ADDR_W'(IFFT_SIZE - 32'(cp_len_o));
  end

  always_ff @(posedge clk) begin
    if (rst) idx_q <= '0;
    else     idx_q <= idx_d;
  end

  assign sym_idx_o = idx_q;

endmodule

// File: rtl/ifft_cp_sched.sv
// IFFT output-buffer read scheduler: CP (symbol tail) then full body, one symbol per sym_ready.
// Define IFFT_CP_SCHED_EXT_CP_EN to add the ext_cp input (extended CP, 12-symbol slots).
module ifft_cp_sched
  import ifft_cp_pkg::*;
#(
  parameter int unsigned IFFT_SIZE = DEF_IFFT_SIZE,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned CP_LONG   = DEF_CP_LONG,
  parameter int unsigned CP_SHORT  = DEF_CP_SHORT,
  parameter int unsigned SYMS_SLOT = DEF_SYMS_SLOT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sym_ready,
`ifdef IFFT_CP_SCHED_EXT_CP_EN
  input  logic              ext_cp,
`endif
  output logic              sym_ack,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              cp_flag,
  output logic              data_valid,
  output logic [3:0]        sym_idx,
  output logic              slot_end,
  output logic              busy
);

  state_t state_q, state_d;

  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                rd_en_q, rd_en_d;
  logic                cp_flag_q, cp_flag_d;
  logic                sym_ack_q, sym_ack_d;
  logic                slot_end_q, slot_end_d;
  logic                busy_q, busy_d;
  logic                data_valid_q;
  logic                adv;
  logic                addr_last;
  logic                last_sym;
  logic [CP_LEN_W-1:0] cp_len;
  logic [ADDR_W-1:0]   start_addr;

  cp_sym_counter #(
    .IFFT_SIZE (IFFT_SIZE),
    .ADDR_W    (ADDR_W),
    .CP_LONG   (CP_LONG),
    .CP_SHORT  (CP_SHORT),
    .SYMS_SLOT (SYMS_SLOT)
  ) u_cnt (
    .clk          (clk),
    .rst          (rst),
    .adv_i        (adv),
`ifdef IFFT_CP_SCHED_EXT_CP_EN
    .idle_i       (state_q == ST_IDLE),
    .ext_cp_i     (ext_cp),
`endif
    .sym_idx_o    (sym_idx),
    .last_sym_o   (last_sym),
    .cp_len_o     (cp_len),
    .start_addr_o (start_addr)
  );

  assign addr_last = (rd_addr_q == ADDR_W'(IFFT_SIZE - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (sym_ready) state_d = ST_CP;
      ST_CP:   if (addr_last) state_d = ST_BODY;
      ST_BODY: if (addr_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; sym_idx advances on the edge entering DONE.
  always_comb begin
    rd_addr_d  = rd_addr_q;
    rd_en_d    = rd_en_q;
    cp_flag_d  = cp_flag_q;
    sym_ack_d  = 1'b0;
    slot_end_d = 1'b0;
    adv        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sym_ready) begin
          rd_addr_d = start_addr;
          rd_en_d   = 1'b1;
          cp_flag_d = 1'b1;
        end
      end
      ST_CP: begin
        if (addr_last) begin
          rd_addr_d = '0;
          cp_flag_d = 1'b0;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      ST_BODY: begin
        if (addr_last) begin
          rd_addr_d  = '0;
          rd_en_d    = 1'b0;
          sym_ack_d  = 1'b1;
          slot_end_d = last_sym;
          adv        = 1'b1;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      default: ;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_q    <= '0;
      rd_en_q      <= 1'b0;
      cp_flag_q    <= 1'b0;
      sym_ack_q    <= 1'b0;
      slot_end_q   <= 1'b0;
      busy_q       <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      rd_addr_q    <= rd_addr_d;
      rd_en_q      <= rd_en_d;
      cp_flag_q    <= cp_flag_d;
      sym_ack_q    <= sym_ack_d;
      slot_end_q   <= slot_end_d;
      busy_q       <= busy_d;
      data_valid_q <= rd_en_q;
    end
  end

  assign rd_addr    = rd_addr_q;
  assign rd_en      = rd_en_q;
  assign cp_flag    = cp_flag_q;
  assign sym_ack    = sym_ack_q;
  assign slot_end   = slot_end_q;
  assign busy       = busy_q;
  assign data_valid = data_valid_q;

endmodule

// File: tb/tb_ifft_cp_sched.sv
// Directed bench for ifft_cp_sched; the extended-CP scenario runs when IFFT_CP_SCHED_EXT_CP_EN is defined.
module tb_ifft_cp_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sym_ready = 1'b0;
`ifdef IFFT_CP_SCHED_EXT_CP_EN
  logic        ext_cp = 1'b0;
`endif
  logic        sym_ack, rd_en, cp_flag, data_valid, slot_end, busy;
  logic [10:0] rd_addr;
  logic [3:0]  sym_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifft_cp_sched #(
    .IFFT_SIZE (2048),
    .ADDR_W    (11),
    .CP_LONG   (160),
    .CP_SHORT  (144),
    .SYMS_SLOT (14)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sym_ready  (sym_ready),
`ifdef IFFT_CP_SCHED_EXT_CP_EN
    .ext_cp     (ext_cp),
`endif
    .sym_ack    (sym_ack),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .cp_flag    (cp_flag),
    .data_valid (data_valid),
    .sym_idx    (sym_idx),
    .slot_end   (slot_end),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Follows one symbol up to and including its sym_ack sample, modelling the expected address stream.
  task automatic observe(input int exp_cp, input bit hold, input bit toggle,
                         output int reads, output int lead, output bit seq_ok,
                         output bit slot_end_seen, output bit timeout);
    logic prev_en;
    int   exp_addr;
    reads = 0; lead = 0; seq_ok = 1'b1; slot_end_seen = 1'b0; timeout = 1'b1;
    prev_en = rd_en;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (data_valid !== prev_en) seq_ok = 1'b0;
      prev_en = rd_en;
      if (sym_ack === 1'b1) begin
        slot_end_seen = slot_end;
        if (rd_en !== 1'b0) seq_ok = 1'b0;
        if (!hold) sym_ready = 1'b0;
        timeout = 1'b0;
        return;
      end
      if (slot_end !== 1'b0) seq_ok = 1'b0;
      if (rd_en === 1'b1) begin
        exp_addr = (reads < exp_cp) ? (2048 - exp_cp + reads) : (reads - exp_cp);
        if (rd_addr !== 11'(exp_addr)) seq_ok = 1'b0;
        if (cp_flag !== (reads < exp_cp)) seq_ok = 1'b0;
        if (busy !== 1'b1) seq_ok = 1'b0;
        reads++;
        if (toggle && (reads % 37 == 0)) sym_ready = ~sym_ready;
      end else if (reads > 0) begin
        seq_ok = 1'b0;
      end else begin
        lead++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sym_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({rd_en, rd_addr, cp_flag, data_valid, sym_ack, slot_end, busy} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", {rd_en, rd_addr, cp_flag, data_valid, sym_ack, slot_end, busy});
    end
    checks++;
    if (sym_idx !== 4'd0) begin errors++; $display("FAIL reset_sym_idx: got %0d expected 0", sym_idx); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_first_symbol();
    int reads, lead; bit ok, se, to;
    sym_ready = 1'b1;
    observe(160, 1'b0, 1'b0, reads, lead, ok, se, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL first_timeout: got %0b expected 0", to); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL first_sequence: got %0b expected 1", ok); end
    checks++; if (reads !== 2208) begin errors++; $display("FAIL first_reads: got %0d expected 2208", reads); end
    checks++; if (lead !== 0) begin errors++; $display("FAIL first_latency: got %0d expected 0", lead); end
    checks++; if (se !== 1'b0) begin errors++; $display("FAIL first_slot_end: got %0b expected 0", se); end
    tick();
    checks++; if (sym_ack !== 1'b0) begin errors++; $display("FAIL first_ack_pulse: got %0b expected 0", sym_ack); end
    checks++; if (sym_idx !== 4'd1) begin errors++; $display("FAIL first_sym_idx: got %0d expected 1", sym_idx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL first_busy_idle: got %0b expected 0", busy); end
  endtask

  task automatic test_short_cp();
    int reads, lead; bit ok, se, to;
    sym_ready = 1'b1;
    observe(144, 1'b0, 1'b0, reads, lead, ok, se, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL short_timeout: got %0b expected 0", to); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL short_sequence: got %0b expected 1", ok); end
    checks++; if (reads !== 2192) begin errors++; $display("FAIL short_reads: got %0d expected 2192", reads); end
    tick();
    checks++; if (sym_idx !== 4'd2) begin errors++; $display("FAIL short_sym_idx: got %0d expected 2", sym_idx); end
  endtask

  task automatic test_reset_mid();
    int reads, lead, acks; bit ok, se, to, found;
    found = 1'b0;
    sym_ready = 1'b1;
    for (int c = 0; c < 3000 && !found; c++) begin
      tick();
      if (rd_en === 1'b1 && cp_flag === 1'b0 && rd_addr === 11'd1000) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL midrst_reach_1000: got %0b expected 1", found); end
    rst = 1'b1; sym_ready = 1'b0;
    tick();
    checks++;
    if ({rd_en, rd_addr, cp_flag, data_valid, sym_ack, slot_end, busy} !== '0) begin
      errors++; $display("FAIL midrst_outputs: got %h expected 0", {rd_en, rd_addr, cp_flag, data_valid, sym_ack, slot_end, busy});
    end
    checks++; if (sym_idx !== 4'd0) begin errors++; $display("FAIL midrst_sym_idx: got %0d expected 0", sym_idx); end
    rst = 1'b0;
    acks = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (sym_ack !== 1'b0 || busy !== 1'b0) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL midrst_no_ack: got %0d expected 0", acks); end
    sym_ready = 1'b1;
    observe(160, 1'b0, 1'b0, reads, lead, ok, se, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL midrst_timeout: got %0b expected 0", to); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL midrst_sequence: got %0b expected 1", ok); end
    checks++; if (reads !== 2208) begin errors++; $display("FAIL midrst_reads: got %0d expected 2208", reads); end
    tick();
  endtask

  task automatic test_ready_ignored();
    int reads, lead, bad; bit ok, se, to;
    sym_ready = 1'b1;
    observe(144, 1'b0, 1'b1, reads, lead, ok, se, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL ignore_timeout: got %0b expected 0", to); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ignore_sequence: got %0b expected 1", ok); end
    checks++; if (reads !== 2192) begin errors++; $display("FAIL ignore_reads: got %0d expected 2192", reads); end
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (busy !== 1'b0 || rd_en !== 1'b0 || sym_ack !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL idle_quiet: got %0d active cycles expected 0", bad); end
    checks++; if (sym_idx !== 4'd2) begin errors++; $display("FAIL idle_sym_idx: got %0d expected 2", sym_idx); end
  endtask

  task automatic test_back_to_back(input int nsyms, input bit ext);
    int reads, lead, total, exp_cp; bit ok, se, to;
    rst = 1'b1; sym_ready = 1'b0;
    tick();
    rst = 1'b0; sym_ready = 1'b1;
    total = 0;
    for (int s = 0; s < nsyms; s++) begin
      exp_cp = ext ? 512 : ((s == 0 || s == 7) ? 160 : 144);
      observe(exp_cp, 1'b1, 1'b0, reads, lead, ok, se, to);
      if (s == nsyms - 1) sym_ready = 1'b0;
      total += reads;
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL slot_timeout sym %0d: got %0b expected 0", s, to); end
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL slot_sequence sym %0d: got %0b expected 1", s, ok); end
      checks++; if (reads !== exp_cp + 2048) begin errors++; $display("FAIL slot_reads sym %0d: got %0d expected %0d", s, reads, exp_cp + 2048); end
      checks++; if (lead !== 0) begin errors++; $display("FAIL slot_gap sym %0d: got %0d expected 2", s, lead + 2); end
      checks++; if (se !== (s == nsyms - 1)) begin errors++; $display("FAIL slot_end sym %0d: got %0b expected %0b", s, se, s == nsyms - 1); end
`ifdef IFFT_CP_SCHED_EXT_CP_EN
      ext_cp = 1'b0;
`endif
      tick();
      checks++; if (sym_ack !== 1'b0 || rd_en !== 1'b0) begin errors++; $display("FAIL slot_idle sym %0d: got ack %0b rd_en %0b expected 0 0", s, sym_ack, rd_en); end
      checks++; if (sym_idx !== 4'((s + 1) % nsyms)) begin errors++; $display("FAIL slot_sym_idx sym %0d: got %0d expected %0d", s, sym_idx, (s + 1) % nsyms); end
    end
    checks++; if (total !== 30720) begin errors++; $display("FAIL slot_total: got %0d expected 30720", total); end
  endtask

`ifdef IFFT_CP_SCHED_EXT_CP_EN
  task automatic test_ext_cp();
    int reads, lead; bit ok, se, to;
    ext_cp = 1'b1;
    test_back_to_back(12, 1'b1);
    ext_cp = 1'b0;
    sym_ready = 1'b1;
    observe(160, 1'b0, 1'b0, reads, lead, ok, se, to);
    checks++; if (ok !== 1'b1 || to !== 1'b0) begin errors++; $display("FAIL ext_relatch: got ok %0b timeout %0b expected 1 0", ok, to); end
    checks++; if (reads !== 2208) begin errors++; $display("FAIL ext_relatch_reads: got %0d expected 2208", reads); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_first_symbol();
    test_short_cp();
    test_reset_mid();
    test_ready_ignored();
    test_back_to_back(14, 1'b0);
`ifdef IFFT_CP_SCHED_EXT_CP_EN
    test_ext_cp();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
